seq_skip_addsub: RTL and testbench

//  Multi-cycle, parametrised carry-skip adder/subtractor for the datapath.

---
 rtl/seq_skip_addsub.sv | 127 ++++++++++++
 tb/tb_seq_skip_addsub.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_skip_addsub.sv
// Multi-cycle carry-skip adder/subtractor: one BLK-bit chunk per clock, LSB first,
// with valid/ready handshakes and a sign-extended WIDTH+EXT result.
module seq_skip_addsub #(
   parameter int WIDTH = 32,
   parameter int BLK   = 8,
   parameter int EXT   = 2
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [WIDTH-1:0]                    x,
   input  logic [WIDTH-1:0]                    y,
   input  logic                                cin,
   input  logic                                sub,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [WIDTH+EXT-1:0]                sum,
   output logic                                cout,
   output logic                                ovf,
   output logic                                zero,
   output logic [$clog2(WIDTH/BLK+1)-1:0]      skip_cnt
);

   localparam int NCH = WIDTH / BLK;
   localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int SW  = $clog2(NCH + 1);
   localparam int RW  = WIDTH + EXT;
   localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

   if (WIDTH % BLK != 0) begin : g_bad_blk
      $error("seq_skip_addsub: WIDTH must be a multiple of BLK");
   end
   if (EXT < 0 || EXT > 4) begin : g_bad_ext
      $error("seq_skip_addsub: EXT must be in 0..4");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [KW-1:0]    k;
   logic             c;
   logic [WIDTH-1:0] x_r;
   logic [WIDTH-1:0] ym_r;

   logic [BLK-1:0]   x_k, ym_k, s_k;
   logic             c_k, p_k, c_next, last, ovf_n, zero_n;
   logic [RW-1:0]    sum_n;

   // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
   always_comb begin
      x_k    = x_r[int'(k)*BLK +: BLK];
      ym_k   = ym_r[int'(k)*BLK +: BLK];
      {c_k, s_k} = {1'b0, x_k} + {1'b0, ym_k} + {{BLK{1'b0}}, c};
      p_k    = &(x_k ^ ym_k);
      // An all-propagate chunk passes its carry-in straight through; same value as the ripple.
      c_next = p_k ? c : c_k;
      last   = (k == K_LAST);
      sum_n  = sum;
      sum_n[int'(k)*BLK +: BLK] = s_k;
      if (last) begin
         for (int i = WIDTH; i < RW; i++)
            sum_n[i] = x_r[WIDTH-1] ^ ym_r[WIDTH-1] ^ c_next;
      end
      // Carry into the MSB is recovered from the MSB sum bit.
      ovf_n  = x_r[WIDTH-1] ^ ym_r[WIDTH-1] ^ sum_n[WIDTH-1] ^ c_next;
      zero_n = ~|sum_n[WIDTH-1:0];
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         k         <= '0;
         c         <= 1'b0;
         x_r       <= '0;
         ym_r      <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
         skip_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_r      <= x;
                  ym_r     <= sub ? ~y : y;
                  c        <= sub | cin;
                  k        <= '0;
                  skip_cnt <= '0;
                  cout     <= 1'b0;
                  ovf      <= 1'b0;
                  zero     <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               sum <= sum_n;
               c   <= c_next;
               if (p_k) skip_cnt <= skip_cnt + SW'(1);
               if (last) begin
                  cout      <= c_next;
                  ovf       <= ovf_n;
                  zero      <= zero_n;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  k <= k + KW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_skip_addsub.sv
// Bench for seq_skip_addsub (WIDTH=32, BLK=8, EXT=2): directed table, handshake and
// reset corner cases, then random operations against an arithmetic reference model.
module tb_seq_skip_addsub;

   localparam int WIDTH = 32;
   localparam int BLK   = 8;
   localparam int EXT   = 2;
   localparam int NCH   = WIDTH / BLK;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WIDTH-1:0]  x = '0;
   logic [WIDTH-1:0]  y = '0;
   logic              cin = 1'b0;
   logic              sub = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [WIDTH+EXT-1:0] sum;
   logic              cout, ovf, zero;
   logic [2:0]        skip_cnt;

   int n_vec  = 0;
   int n_fail = 0;

   seq_skip_addsub #(.WIDTH(WIDTH), .BLK(BLK), .EXT(EXT)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .skip_cnt(skip_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] x, y;
      logic        cin, sub;
      logic [33:0] sum;
      logic        cout, ovf, zero;
      logic [2:0]  skip;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: exact signed arithmetic, unsigned compare for the carry, chunk-wise propagate count.
   function automatic vec_t model(input logic [31:0] mx, input logic [31:0] my,
                                  input logic mcin, input logic msub);
      vec_t   r;
      longint xs, ys, exact;
      logic [63:0] u;
      logic [31:0] ym;
      int     sk;
      xs = $signed(mx);
      ys = $signed(my);
      exact = msub ? (xs - ys) : (xs + ys + longint'(mcin));
      u = 64'(mx) + 64'(my) + 64'(mcin);
      ym = msub ? ~my : my;
      sk = 0;
      for (int i = 0; i < NCH; i++)
         if (((mx ^ ym) >> (8 * i)) % 256 == 255) sk++;
      r.x = mx; r.y = my; r.cin = mcin; r.sub = msub;
      r.sum  = exact[33:0];
      r.cout = msub ? (mx >= my) : u[32];
      r.ovf  = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
      r.zero = (exact[31:0] == 32'd0);
      r.skip = 3'(sk);
      return r;
   endfunction

   // Presents one operand pair at a point away from the edge and returns after the accepting edge.
   task automatic start_op(input logic [31:0] ox, input logic [31:0] oy, input logic ocin,
                           input logic osub);
      @(negedge clk);
      check("in_ready_before_accept", 64'(in_ready), 64'd1);
      x = ox; y = oy; cin = ocin; sub = osub; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int lat;
      lat = 0;
      while (1) begin
         @(posedge clk);
         lat++;
         #1;
         if (out_valid) break;
         if (lat > 40) break;
      end
      check({name, "_latency"}, 64'(lat), 64'(NCH));
   endtask

   task automatic check_result(input string name, input vec_t e);
      check({name, "_sum"},  64'(sum),      64'(e.sum));
      check({name, "_cout"}, 64'(cout),     64'(e.cout));
      check({name, "_ovf"},  64'(ovf),      64'(e.ovf));
      check({name, "_zero"}, 64'(zero),     64'(e.zero));
      check({name, "_skip"}, 64'(skip_cnt), 64'(e.skip));
   endtask

   task automatic release_result(input string name);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({name, "_out_valid_after_take"}, 64'(out_valid), 64'd0);
      check({name, "_in_ready_after_take"},  64'(in_ready),  64'd1);
   endtask

   vec_t tbl[4];
   vec_t e;
   logic [33:0] held_sum;

   initial begin
      tbl[0] = '{x:32'd10, y:32'd15, cin:1'b0, sub:1'b0, sum:34'h0_0000_0019,
                 cout:1'b0, ovf:1'b0, zero:1'b0, skip:3'd0};
      tbl[1] = '{x:32'hFFFF_FFFF, y:32'd1, cin:1'b0, sub:1'b0, sum:34'h0,
                 cout:1'b1, ovf:1'b0, zero:1'b1, skip:3'd3};
      tbl[2] = '{x:32'h7FFF_FFFF, y:32'hFFFF_FFFF, cin:1'b0, sub:1'b1, sum:34'h0_8000_0000,
                 cout:1'b0, ovf:1'b1, zero:1'b0, skip:3'd3};
      tbl[3] = '{x:32'd5, y:32'd7, cin:1'b0, sub:1'b1, sum:34'h3_FFFF_FFFE,
                 cout:1'b0, ovf:1'b0, zero:1'b0, skip:3'd3};

      // Reset state
      #12;
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum",       64'(sum),       64'd0);
      check("rst_flags",     64'({cout, ovf, zero}), 64'd0);
      check("rst_skip",      64'(skip_cnt),  64'd0);
      @(negedge clk) rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 4; i++) begin
         start_op(tbl[i].x, tbl[i].y, tbl[i].cin, tbl[i].sub);
         check("busy_in_ready", 64'(in_ready), 64'd0);
         wait_done("tbl");
         check_result("tbl", tbl[i]);
         release_result("tbl");
      end

      // Back-pressure: outputs hold, in_ready low, new in_valid ignored
      e = model(32'd100, 32'd3, 1'b1, 1'b0);
      start_op(32'd100, 32'd3, 1'b1, 1'b0);
      wait_done("hold");
      held_sum = sum;
      check("hold_sum_first", 64'(held_sum), 64'(e.sum));
      x = 32'hDEAD_BEEF; y = 32'h1234_5678; sub = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("hold_sum",       64'(sum),       64'(held_sum));
         check("hold_out_valid", 64'(out_valid), 64'd1);
         check("hold_in_ready",  64'(in_ready),  64'd0);
      end
      in_valid = 1'b0;
      check_result("hold", e);
      release_result("hold");
      check("hold_sum_after_take", 64'(sum), 64'(held_sum));

      // Reset during the second RUN cycle aborts the operation
      start_op(32'h0F0F_0F0F, 32'h1111_1111, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_in_ready",  64'(in_ready),  64'd1);
      check("abort_sum",       64'(sum),       64'd0);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) break;
      end
      check("abort_no_result", 64'(out_valid), 64'd0);
      start_op(32'd1, 32'd2, 1'b0, 1'b0);
      wait_done("post_abort");
      check_result("post_abort", model(32'd1, 32'd2, 1'b0, 1'b0));
      release_result("post_abort");

      // Random operations against the reference model
      for (int i = 0; i < 60; i++) begin
         logic [31:0] rx, ry;
         logic rc, rs;
         int   dly;
         rx = $urandom;
         ry = $urandom;
         rc = 1'($urandom_range(1));
         rs = 1'($urandom_range(1));
         case ($urandom_range(5))
            0: ry = ~rx;
            1: ry = rx;
            2: rx = 32'h8000_0000;
            default: ;
         endcase
         e = model(rx, ry, rc, rs);
         start_op(rx, ry, rc, rs);
         wait_done("rnd");
         dly = $urandom_range(3);
         repeat (dly) @(posedge clk);
         #1;
         check("rnd_out_valid_held", 64'(out_valid), 64'd1);
         check_result("rnd", e);
         release_result("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
